// File: rtl/brick_level_loader.sv
// brick_level_loader: walks the ROWS x COLS brick grid of one level held in an
// external synchronous ROM and emits one record (x, y, type, cell index) per
// present brick over a load/ready handshake. One cell costs FETCH, WAIT and
// EMIT cycles; a consumer stall only stretches EMIT.
module brick_level_loader #(
    parameter int COLS       = 10,
    parameter int ROWS       = 5,
    parameter int NUM_LEVELS = 4,
    parameter int BRICK_W    = 16,
    parameter int BRICK_H    = 8,
    parameter int X_ORIGIN   = 0,
    parameter int Y_ORIGIN   = 0,
    parameter int COORD_W    = 10,
    parameter int ADDR_W     = 10,
    parameter int TYPE_W     = 3,
    parameter int EMIT_EMPTY = 0
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic [7:0]         selection,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [TYPE_W-1:0]  rom_data,
    output logic               load,
    input  logic               ready,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [TYPE_W-1:0]  brick_type,
    output logic [ADDR_W-1:0]  address,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  brick_count
);

    localparam int CELLS = ROWS * COLS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EMIT,
        S_FIN
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0]  rom_ptr;     // absolute ROM address of the current cell
    logic [ADDR_W-1:0]  cell_index;  // level-relative cell index
    logic [ADDR_W-1:0]  col;
    logic [ADDR_W-1:0]  row;
    logic [COORD_W-1:0] x_acc;
    logic [COORD_W-1:0] y_acc;
    logic [TYPE_W-1:0]  type_reg;
    logic [ADDR_W-1:0]  count;

    logic [7:0]         level_pick;
    logic [ADDR_W-1:0]  level_base;
    logic               present;
    logic               last_cell;
    logic               step;

    // Out-of-range selections fall back to level 0; the level base is formed
    // once per start and afterwards the ROM pointer only increments.
    assign level_pick = (int'(selection) >= NUM_LEVELS) ? 8'd0 : selection;
    assign level_base = ADDR_W'(int'(level_pick) * CELLS);
    assign present    = (type_reg != '0) || (EMIT_EMPTY != 0);
    assign last_cell  = (row == ADDR_W'(ROWS - 1)) && (col == ADDR_W'(COLS - 1));

    assign rom_addr    = rom_ptr;
    assign x_out       = x_acc;
    assign y_out       = y_acc;
    assign brick_type  = type_reg;
    assign address     = cell_index;
    assign brick_count = count;

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and handshake outputs; step marks leaving a cell.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        step       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy       = 1'b1;
                state_next = S_EMIT;
            end
            S_EMIT: begin
                busy = 1'b1;
                load = present;
                step = !present || ready;
                if (step) begin
                    state_next = last_cell ? S_FIN : S_FETCH;
                end
            end
            S_FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Cell walker: ROM pointer, grid position, coordinate accumulators, count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rom_ptr    <= '0;
            cell_index <= '0;
            col        <= '0;
            row        <= '0;
            x_acc      <= '0;
            y_acc      <= '0;
            type_reg   <= '0;
            count      <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                rom_ptr    <= level_base;
                cell_index <= '0;
                col        <= '0;
                row        <= '0;
                x_acc      <= COORD_W'(X_ORIGIN);
                y_acc      <= COORD_W'(Y_ORIGIN);
                count      <= '0;
            end
            if (state == S_WAIT) begin
                type_reg <= rom_data;
            end
            if (step) begin
                if (present) begin
                    count <= count + 1'b1;
                end
                if (!last_cell) begin
                    rom_ptr    <= rom_ptr + 1'b1;
                    cell_index <= cell_index + 1'b1;
                    if (col == ADDR_W'(COLS - 1)) begin
                        col   <= '0;
                        x_acc <= COORD_W'(X_ORIGIN);
                        row   <= row + 1'b1;
                        y_acc <= y_acc + COORD_W'(BRICK_H);
                    end else begin
                        col   <= col + 1'b1;
                        x_acc <= x_acc + COORD_W'(BRICK_W);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_brick_level_loader.sv
// Bench for brick_level_loader: two instances (empty cells skipped / emitted)
// share one ROM image; a vector table drives whole level loads while a
// scoreboard queue holds the records each load should produce.
module tb_brick_level_loader;

    localparam int COLS   = 10;
    localparam int ROWS   = 5;
    localparam int LEVELS = 4;
    localparam int CELLS  = COLS * ROWS;

    localparam int PAT_ALL2   = 0;
    localparam int PAT_SPARSE = 1;
    localparam int PAT_MIXED  = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [7:0] selection = 8'd0;
    logic ready = 1'b1;

    logic [9:0] rom_addr0, rom_addr1, x0, x1, y0, y1, addr0, addr1, cnt0, cnt1;
    logic [2:0] rom_data0, rom_data1, type0, type1;
    logic load0, load1, busy0, busy1, done0, done1;

    logic [2:0] mem [0:LEVELS*CELLS-1];

    always #5 clk = ~clk;

    // Synchronous ROM models, one word of latency.
    always @(posedge clk) rom_data0 <= mem[rom_addr0];
    always @(posedge clk) rom_data1 <= mem[rom_addr1];

    brick_level_loader #(.EMIT_EMPTY(0)) dut0 (
        .clk(clk), .resetn(resetn), .start(start0), .selection(selection),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .load(load0), .ready(ready),
        .x_out(x0), .y_out(y0), .brick_type(type0), .address(addr0),
        .busy(busy0), .done(done0), .brick_count(cnt0));

    brick_level_loader #(.EMIT_EMPTY(1)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .selection(selection),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .load(load1), .ready(ready),
        .x_out(x1), .y_out(y1), .brick_type(type1), .address(addr1),
        .busy(busy1), .done(done1), .brick_count(cnt1));

    // View of whichever instance the current test targets.
    int cur = 0;
    logic [9:0] o_rom_addr, o_x, o_y, o_addr, o_cnt;
    logic [2:0] o_type;
    logic o_load, o_busy, o_done;
    always_comb begin
        o_rom_addr = (cur == 1) ? rom_addr1 : rom_addr0;
        o_x        = (cur == 1) ? x1 : x0;
        o_y        = (cur == 1) ? y1 : y0;
        o_addr     = (cur == 1) ? addr1 : addr0;
        o_cnt      = (cur == 1) ? cnt1 : cnt0;
        o_type     = (cur == 1) ? type1 : type0;
        o_load     = (cur == 1) ? load1 : load0;
        o_busy     = (cur == 1) ? busy1 : busy0;
        o_done     = (cur == 1) ? done1 : done0;
    end

    typedef struct packed {
        logic [9:0] addr;
        logic [9:0] x;
        logic [9:0] y;
        logic [2:0] t;
    } rec_t;

    rec_t sb[$];

    typedef struct {
        int         d;
        logic [7:0] sel;
        int         lvl;
        int         pat;
        int         stall_rec;
        int         busy_start_cyc;
        bit         fin_start;
        int         exp_count;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_start(input int d, input logic v);
        if (d == 1) start1 = v;
        else        start0 = v;
    endtask

    task automatic fill(input int lvl, input int pat);
        for (int i = 0; i < LEVELS * CELLS; i++) mem[i] = 3'd3;
        for (int i = 0; i < CELLS; i++) begin
            case (pat)
                PAT_ALL2:   mem[lvl*CELLS+i] = 3'd2;
                PAT_SPARSE: mem[lvl*CELLS+i] = (i == 0) ? 3'd1 : (i == 9) ? 3'd5 : (i == 49) ? 3'd7 : 3'd0;
                default:    mem[lvl*CELLS+i] = 3'(i % 3);
            endcase
        end
    endtask

    task automatic run_load(input vec_t v);
        int   recs = 0, stall_n = 0, done_n = 0;
        bit   fin_seen = 0, finished = 0;
        rec_t exp, got, snap;
        logic [9:0] snap_cnt;
        logic [2:0] t;
        snap = '0;
        snap_cnt = '0;
        sb.delete();
        for (int i = 0; i < CELLS; i++) begin
            t = mem[v.lvl*CELLS+i];
            if (t != 3'd0 || v.d == 1)
                sb.push_back('{addr: 10'(i), x: 10'((i % COLS) * 16), y: 10'((i / COLS) * 8), t: t});
        end
        cur = v.d;
        selection = v.sel;
        ready = 1'b1;
        drive_start(v.d, 1'b1);
        @(negedge clk);
        drive_start(v.d, 1'b0);
        check("busy_after_start", 64'(o_busy), 64'd1);
        check("first_rom_addr", 64'(o_rom_addr), 64'(v.lvl * CELLS));
        for (int cyc = 0; cyc < 1000 && !finished; cyc++) begin
            drive_start(v.d, 1'b0);
            if (cyc == v.busy_start_cyc) drive_start(v.d, 1'b1);
            ready = 1'b1;
            if (fin_seen) begin
                check("done_width", 64'(o_done), 64'd0);
                check("busy_after_done", 64'(o_busy), 64'd0);
                finished = 1;
            end else if (o_done) begin
                done_n++;
                fin_seen = 1;
                check("load_in_fin", 64'(o_load), 64'd0);
                if (v.fin_start) drive_start(v.d, 1'b1);
            end else if (o_load) begin
                got = '{addr: o_addr, x: o_x, y: o_y, t: o_type};
                if (recs == v.stall_rec && stall_n < 5) begin
                    ready = 1'b0;
                    if (stall_n == 0) begin
                        snap = got;
                        snap_cnt = o_cnt;
                    end else begin
                        check("stall_record_stable", 64'(got), 64'(snap));
                        check("stall_count_stable", 64'(o_cnt), 64'(snap_cnt));
                    end
                    stall_n++;
                end else begin
                    if (sb.size() == 0) begin
                        check("extra_record", 64'(got), 64'h0);
                        n_fail++;
                        $display("FAIL extra_record: got record beyond expected %0d", v.exp_count);
                    end else begin
                        exp = sb.pop_front();
                        check("record", 64'(got), 64'(exp));
                    end
                    recs++;
                end
            end
            @(negedge clk);
        end
        if (!finished) begin
            n_vec++;
            n_fail++;
            $display("FAIL load_timeout: got no done, required done within 1000 cycles");
        end
        drive_start(v.d, 1'b0);
        check("done_pulses", 64'(done_n), 64'd1);
        check("records_seen", 64'(recs), 64'(v.exp_count));
        check("records_missing", 64'(sb.size()), 64'd0);
        check("brick_count", 64'(o_cnt), 64'(v.exp_count));
        repeat (3) @(negedge clk);
        check("idle_busy", 64'(o_busy), 64'd0);
        check("count_hold", 64'(o_cnt), 64'(v.exp_count));
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{0, 8'd1, 1, PAT_ALL2,   -1, -1, 1'b0, 50};
        vecs[1] = '{0, 8'd0, 0, PAT_SPARSE, -1, -1, 1'b0, 3};
        vecs[2] = '{0, 8'd7, 0, PAT_SPARSE, -1, 10, 1'b1, 3};
        vecs[3] = '{0, 8'd2, 2, PAT_MIXED,   2, -1, 1'b0, 33};
        vecs[4] = '{1, 8'd3, 3, PAT_MIXED,   2, 20, 1'b0, 50};
        vecs[5] = '{0, 8'd1, 1, PAT_ALL2,    2, -1, 1'b1, 50};

        fill(0, PAT_ALL2);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        cur = 0;
        check("reset_outputs",
              64'({load0, busy0, done0, cnt0, x0, y0, type0, addr0, rom_addr0}), 64'd0);

        for (int k = 0; k < 6; k++) begin
            fill(vecs[k].lvl, vecs[k].pat);
            run_load(vecs[k]);
        end

        // Reset while a record is being offered.
        fill(1, PAT_ALL2);
        cur = 0;
        selection = 8'd1;
        ready = 1'b0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < 20 && !load0; i++) @(negedge clk);
        check("pre_reset_load", 64'(load0), 64'd1);
        resetn = 1'b0;
        @(negedge clk);
        check("reset_mid_emit", 64'({load0, busy0, done0, cnt0}), 64'd0);
        resetn = 1'b1;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 64'({load0, busy0, done0}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
